// File: rtl/alu_mdu_pkg.sv
// alu_mdu_pkg: shared definitions for the multiply/divide unit.
//   - MDU operation encodings (3 bits) and their width
//   - FSM state encodings
package alu_mdu_pkg;

    localparam int MDU_OP_WIDTH = 3;

    typedef enum logic [MDU_OP_WIDTH-1:0] {
        MDU_MUL    = 3'd0,
        MDU_MULH   = 3'd1,
        MDU_MULHSU = 3'd2,
        MDU_MULHU  = 3'd3,
        MDU_DIV    = 3'd4,
        MDU_DIVU   = 3'd5,
        MDU_REM    = 3'd6,
        MDU_REMU   = 3'd7
    } mdu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } mdu_state_e;

endpackage

// File: rtl/alu_mdu_if.sv
// alu_mdu_if: dispatch-side and writeback-side handshake bundle of alu_mdu.
//   disp2mdu_vld/rdy  : operation offer / accept (rdy only in IDLE)
//   dec2mdu_*         : op, *W flag, operands, destination register
//   mdu_flush         : abort in-flight operation
//   mdu2wb_vld/rdy    : result offer / writeback accept
//   mdu2wb_data/rdidx : result and captured destination
// Modport slave is the unit itself, master is the dispatch/writeback side.
interface alu_mdu_if #(
    parameter int XLEN = 64
);
    logic            disp2mdu_vld;
    logic            disp2mdu_rdy;
    logic [2:0]      dec2mdu_op;
    logic            dec2mdu_resw;
    logic [XLEN-1:0] dec2mdu_rs1;
    logic [XLEN-1:0] dec2mdu_rs2;
    logic [4:0]      dec2mdu_rdidx;
    logic            mdu_flush;
    logic            mdu2wb_vld;
    logic            mdu2wb_rdy;
    logic [XLEN-1:0] mdu2wb_data;
    logic [4:0]      mdu2wb_rdidx;

    modport slave (
        input  disp2mdu_vld, dec2mdu_op, dec2mdu_resw, dec2mdu_rs1, dec2mdu_rs2,
               dec2mdu_rdidx, mdu_flush, mdu2wb_rdy,
        output disp2mdu_rdy, mdu2wb_vld, mdu2wb_data, mdu2wb_rdidx
    );

    modport master (
        output disp2mdu_vld, dec2mdu_op, dec2mdu_resw, dec2mdu_rs1, dec2mdu_rs2,
               dec2mdu_rdidx, mdu_flush, mdu2wb_rdy,
        input  disp2mdu_rdy, mdu2wb_vld, mdu2wb_data, mdu2wb_rdidx
    );
endinterface

// File: rtl/alu_mdu_div_iter.sv
// alu_mdu_div_iter: one restoring-division step on unsigned magnitudes.
//   rem_in  : current partial remainder (always < divisor)
//   dvd_bit : next dividend bit shifted in
//   divisor : divisor magnitude (non-zero)
//   rem_out : next partial remainder
//   q_bit   : quotient bit produced by this step
module alu_mdu_div_iter #(
    parameter int XLEN = 64
) (
    input  logic [XLEN-1:0] rem_in,
    input  logic            dvd_bit,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] rem_out,
    output logic            q_bit
);
    logic [XLEN:0] shifted;
    logic [XLEN:0] diff;

    assign shifted = {rem_in, dvd_bit};
    assign diff    = shifted - {1'b0, divisor};
    // rem_in < divisor keeps a non-negative difference below 2^XLEN,
    // so the top bit alone tells whether the subtraction fits.
    assign q_bit   = ~diff[XLEN];
    assign rem_out = q_bit ? diff[XLEN-1:0] : shifted[XLEN-1:0];
endmodule

// File: rtl/alu_mdu.sv
// alu_mdu: iterative RV M-extension multiply/divide unit.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : alu_mdu_if.slave (dispatch handshake, operands, flush,
//                writeback handshake, result, destination index)
// Optional feature: MYRISCV_MDU_FAST_MUL_EN builds a single-cycle
// (XLEN+1)x(XLEN+1) signed multiplier in place of the shift-add path.
//
// state | meaning
// IDLE  | ready to accept an operation
// BUSY  | iterating; counter counts remaining steps down to 0
// DONE  | result held on writeback port until mdu2wb_rdy
module alu_mdu
    import alu_mdu_pkg::*;
#(
    parameter int XLEN = 64
) (
    input logic      clk,
    input logic      rst_n,
    alu_mdu_if.slave bus
);
`ifdef MYRISCV_MDU_FAST_MUL_EN
    localparam int MULW_SHIFT = 0;
`else
    localparam int MULW_SHIFT = XLEN - 32;
`endif

    mdu_state_e      state, state_nxt;
    mdu_op_e         op_q;
    logic            w_q, sign_a_q, sign_b_q, dz_q, ov_q;
    logic [5:0]      cnt;
    logic [XLEN-1:0] acc_hi, acc_lo, opb, data_q;
    logic [4:0]      rdidx_q;

    // ---------------- operand preparation at accept ----------------
    mdu_op_e         op_in;
    logic            accept, in_div, in_sdiv, in_mulh, in_w;
    logic            a_signed, b_signed, sign_a, sign_b, dz_in, ov_in;
    logic [63:0]     rs1_w64, rs2_w64;
    logic [63:0]     min_w64;
    logic [XLEN-1:0] ext_a, ext_b, mag_a, mag_b, min_val, dvd_load;

    assign op_in    = mdu_op_e'(bus.dec2mdu_op);
    assign accept   = bus.disp2mdu_vld && (state == ST_IDLE);
    assign in_div   = op_in[2];
    assign in_sdiv  = (op_in == MDU_DIV) || (op_in == MDU_REM);
    assign in_mulh  = (op_in == MDU_MULH) || (op_in == MDU_MULHSU) || (op_in == MDU_MULHU);
    assign in_w     = (XLEN == 64) && bus.dec2mdu_resw && !in_mulh;
    assign a_signed = in_sdiv || (op_in == MDU_MULH) || (op_in == MDU_MULHSU);
    assign b_signed = in_sdiv || (op_in == MDU_MULH);

    // *W forms: DIVW/REMW sign-extend from bit 31, the others zero-extend
    assign rs1_w64 = {{32{in_sdiv & bus.dec2mdu_rs1[31]}}, bus.dec2mdu_rs1[31:0]};
    assign rs2_w64 = {{32{in_sdiv & bus.dec2mdu_rs2[31]}}, bus.dec2mdu_rs2[31:0]};
    assign ext_a   = in_w ? rs1_w64[XLEN-1:0] : bus.dec2mdu_rs1;
    assign ext_b   = in_w ? rs2_w64[XLEN-1:0] : bus.dec2mdu_rs2;

    assign sign_a  = a_signed & ext_a[XLEN-1];
    assign sign_b  = b_signed & ext_b[XLEN-1];
    assign mag_a   = sign_a ? -ext_a : ext_a;
    assign mag_b   = sign_b ? -ext_b : ext_b;

    assign min_w64 = 64'hFFFF_FFFF_8000_0000;
    assign min_val = in_w ? min_w64[XLEN-1:0] : {1'b1, {(XLEN-1){1'b0}}};
    assign dz_in   = in_div && (ext_b == '0);
    assign ov_in   = in_sdiv && (ext_a == min_val) && (ext_b == '1);

    // W divides run 32 steps, so the 32-bit dividend is parked at the top
    assign dvd_load = in_w ? (mag_a << (XLEN - 32)) : mag_a;

    // ---------------- one iteration step ----------------
    logic [XLEN-1:0] hi_n, lo_n, div_rem;
    logic            div_q;

    alu_mdu_div_iter #(.XLEN(XLEN)) u_div_iter (
        .rem_in  (acc_hi),
        .dvd_bit (acc_lo[XLEN-1]),
        .divisor (opb),
        .rem_out (div_rem),
        .q_bit   (div_q)
    );

`ifndef MYRISCV_MDU_FAST_MUL_EN
    logic [XLEN:0] mul_sum;
    assign mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opb} : '0);
`endif

    always_comb begin
        hi_n = acc_hi;
        lo_n = acc_lo;
        if (op_q[2]) begin
            hi_n = div_rem;
            lo_n = {acc_lo[XLEN-2:0], div_q};
        end
`ifndef MYRISCV_MDU_FAST_MUL_EN
        else begin
            hi_n = mul_sum[XLEN:1];
            lo_n = {mul_sum[0], acc_lo[XLEN-1:1]};
        end
`endif
    end

    // ---------------- result formation on the last step ----------------
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   q_fix, r_fix, res_raw, res_final;
    logic [63:0]       res_w64;

`ifdef MYRISCV_MDU_FAST_MUL_EN
    // acc_lo/opb hold the extended operands, the sign flags act as bit XLEN
    logic signed [2*XLEN+1:0] fast_a, fast_b, fast_prod;
    assign fast_a    = {{(XLEN+1){sign_a_q}}, sign_a_q, acc_lo};
    assign fast_b    = {{(XLEN+1){sign_b_q}}, sign_b_q, opb};
    assign fast_prod = fast_a * fast_b;
    assign prod_fix  = fast_prod[2*XLEN-1:0];
`else
    assign prod_fix  = (sign_a_q ^ sign_b_q) ? -{hi_n, lo_n} : {hi_n, lo_n};
`endif

    assign q_fix = (sign_a_q ^ sign_b_q) ? -lo_n : lo_n;
    assign r_fix = sign_a_q ? -hi_n : hi_n;

    always_comb begin
        res_raw = '0;
        case (op_q)
            MDU_MUL:                         res_raw = w_q ? (prod_fix[XLEN-1:0] >> MULW_SHIFT)
                                                           : prod_fix[XLEN-1:0];
            MDU_MULH, MDU_MULHSU, MDU_MULHU: res_raw = prod_fix[2*XLEN-1:XLEN];
            MDU_DIV, MDU_DIVU:               res_raw = dz_q ? '1 : (ov_q ? acc_lo : q_fix);
            MDU_REM, MDU_REMU:               res_raw = dz_q ? acc_lo : (ov_q ? '0 : r_fix);
            default:                         res_raw = '0;
        endcase
    end

    assign res_w64   = {{32{res_raw[31]}}, res_raw[31:0]};
    assign res_final = w_q ? res_w64[XLEN-1:0] : res_raw;

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (bus.disp2mdu_vld) state_nxt = ST_BUSY;
            ST_BUSY: begin
                if (bus.mdu_flush)    state_nxt = ST_IDLE;
                else if (cnt == 6'd0) state_nxt = ST_DONE;
            end
            ST_DONE: if (bus.mdu_flush || bus.mdu2wb_rdy) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.disp2mdu_rdy = (state == ST_IDLE);
        bus.mdu2wb_vld   = (state == ST_DONE);
        bus.mdu2wb_data  = data_q;
        bus.mdu2wb_rdidx = rdidx_q;
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q     <= MDU_MUL;
            w_q      <= 1'b0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            dz_q     <= 1'b0;
            ov_q     <= 1'b0;
            cnt      <= 6'd0;
            acc_hi   <= '0;
            acc_lo   <= '0;
            opb      <= '0;
            data_q   <= '0;
            rdidx_q  <= 5'd0;
        end else if (accept) begin
            op_q     <= op_in;
            w_q      <= in_w;
            sign_a_q <= sign_a;
            sign_b_q <= sign_b;
            dz_q     <= dz_in;
            ov_q     <= ov_in;
            rdidx_q  <= bus.dec2mdu_rdidx;
            acc_hi   <= '0;
            if (in_div) begin
                // special cases keep the raw dividend as their result source
                acc_lo <= (dz_in || ov_in) ? ext_a : dvd_load;
                opb    <= mag_b;
            end else begin
`ifdef MYRISCV_MDU_FAST_MUL_EN
                acc_lo <= ext_a;
                opb    <= ext_b;
`else
                acc_lo <= mag_b;
                opb    <= mag_a;
`endif
            end
            if (dz_in || ov_in)
                cnt <= 6'd0;
`ifdef MYRISCV_MDU_FAST_MUL_EN
            else if (!in_div)
                cnt <= 6'd0;
`endif
            else if (in_w)
                cnt <= 6'd31;
            else
                cnt <= 6'(XLEN - 1);
        end else if (state == ST_BUSY) begin
            acc_hi <= hi_n;
            acc_lo <= lo_n;
            if (cnt != 6'd0)
                cnt <= cnt - 6'd1;
            else if (!bus.mdu_flush)
                data_q <= res_final;
        end
    end
endmodule

// File: tb/tb_alu_mdu.sv
module tb_alu_mdu;
    import alu_mdu_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    alu_mdu_if #(.XLEN(64)) bus ();

    alu_mdu #(.XLEN(64)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic        resw;
        logic [63:0] a;
        logic [63:0] b;
        logic [4:0]  rd;
        logic [63:0] exp;
        int          lat;
    } vec_t;

    localparam int NVEC = 18;
    vec_t vecs[NVEC];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic issue(input logic [2:0] op, input logic resw, input logic [63:0] a,
                         input logic [63:0] b, input logic [4:0] rd);
        @(negedge clk);
        bus.disp2mdu_vld  = 1'b1;
        bus.dec2mdu_op    = op;
        bus.dec2mdu_resw  = resw;
        bus.dec2mdu_rs1   = a;
        bus.dec2mdu_rs2   = b;
        bus.dec2mdu_rdidx = rd;
        chk("rdy_before_accept", 64'(bus.disp2mdu_rdy), 64'd1);
        @(posedge clk);
        #1;
        bus.disp2mdu_vld = 1'b0;
    endtask

    // counts edges after the accept edge until vld is seen
    task automatic wait_done(output int lat);
        lat = 0;
        while (lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
            if (bus.mdu2wb_vld) break;
        end
    endtask

    task automatic release_wb();
        @(negedge clk);
        bus.mdu2wb_rdy = 1'b1;
        @(posedge clk);
        #1;
        bus.mdu2wb_rdy = 1'b0;
        chk("idle_after_wb", {62'd0, bus.disp2mdu_rdy, bus.mdu2wb_vld}, 64'b10);
    endtask

    task automatic run_op(input string name, input logic [2:0] op, input logic resw,
                          input logic [63:0] a, input logic [63:0] b, input logic [4:0] rd,
                          input logic [63:0] exp, input int exp_lat);
        int lat;
        issue(op, resw, a, b, rd);
        chk({name, "_busy_rdy"}, 64'(bus.disp2mdu_rdy), 64'd0);
        wait_done(lat);
        chk({name, "_lat"}, 64'(lat), 64'(exp_lat));
        chk({name, "_data"}, bus.mdu2wb_data, exp);
        chk({name, "_rdidx"}, 64'(bus.mdu2wb_rdidx), 64'(rd));
        release_wb();
    endtask

    initial begin
        int          lat;
        logic        saw_vld;
        logic [63:0] held_data;

        vecs[0]  = '{MDU_DIVU,   1'b0, 64'd100, 64'd7, 5'd1, 64'd14, 64};
        vecs[1]  = '{MDU_REMU,   1'b0, 64'd100, 64'd7, 5'd2, 64'd2, 64};
        vecs[2]  = '{MDU_DIV,    1'b0, -64'sd7, 64'd2, 5'd3, 64'hFFFF_FFFF_FFFF_FFFD, 64};
        vecs[3]  = '{MDU_REM,    1'b0, -64'sd7, 64'd2, 5'd4, 64'hFFFF_FFFF_FFFF_FFFF, 64};
        vecs[4]  = '{MDU_MULH,   1'b0, '1, '1, 5'd5, 64'd0, 64};
        vecs[5]  = '{MDU_MULHU,  1'b0, '1, '1, 5'd6, 64'hFFFF_FFFF_FFFF_FFFE, 64};
        vecs[6]  = '{MDU_DIV,    1'b0, 64'd5, 64'd0, 5'd7, 64'hFFFF_FFFF_FFFF_FFFF, 1};
        vecs[7]  = '{MDU_REM,    1'b0, 64'h8000_0000_0000_0000, '1, 5'd8, 64'd0, 1};
        vecs[8]  = '{MDU_DIV,    1'b1, 64'h0000_0000_8000_0000, '1, 5'd9, 64'hFFFF_FFFF_8000_0000, 1};
        vecs[9]  = '{MDU_MUL,    1'b1, 64'h0000_0000_7FFF_FFFF, 64'd2, 5'd13, 64'hFFFF_FFFF_FFFF_FFFE, 32};
        vecs[10] = '{MDU_MUL,    1'b0, 64'd3, 64'd4, 5'd10, 64'd12, 64};
        vecs[11] = '{MDU_MUL,    1'b0, -64'sd3, 64'd5, 5'd11, 64'hFFFF_FFFF_FFFF_FFF1, 64};
        vecs[12] = '{MDU_MULHSU, 1'b0, '1, 64'd2, 5'd12, 64'hFFFF_FFFF_FFFF_FFFF, 64};
        vecs[13] = '{MDU_DIVU,   1'b1, 64'h1234_5678_FFFF_FFF0, 64'd16, 5'd14, 64'h0000_0000_0FFF_FFFF, 32};
        vecs[14] = '{MDU_REM,    1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2, 5'd15, 64'hFFFF_FFFF_FFFF_FFFF, 32};
        vecs[15] = '{MDU_REMU,   1'b0, 64'd5, 64'd0, 5'd16, 64'd5, 1};
        vecs[16] = '{MDU_DIVU,   1'b0, 64'h8000_0000_0000_0000, '1, 5'd17, 64'd0, 64};
        vecs[17] = '{MDU_DIV,    1'b0, 64'h8000_0000_0000_0000, '1, 5'd18, 64'h8000_0000_0000_0000, 1};

        bus.disp2mdu_vld  = 1'b0;
        bus.dec2mdu_op    = 3'd0;
        bus.dec2mdu_resw  = 1'b0;
        bus.dec2mdu_rs1   = '0;
        bus.dec2mdu_rs2   = '0;
        bus.dec2mdu_rdidx = 5'd0;
        bus.mdu_flush     = 1'b0;
        bus.mdu2wb_rdy    = 1'b0;

        // reset state
        repeat (3) @(negedge clk);
        chk("reset_rdy", 64'(bus.disp2mdu_rdy), 64'd1);
        chk("reset_vld", 64'(bus.mdu2wb_vld), 64'd0);
        chk("reset_data", bus.mdu2wb_data, 64'd0);
        chk("reset_rdidx", 64'(bus.mdu2wb_rdidx), 64'd0);
        rst_n = 1'b1;

        for (int i = 0; i < NVEC; i++)
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].resw, vecs[i].a, vecs[i].b,
                   vecs[i].rd, vecs[i].exp, vecs[i].lat);

        // backpressure: result and rdidx hold while writeback stalls
        issue(MDU_MUL, 1'b0, 64'd6, 64'd7, 5'd9);
        wait_done(lat);
        chk("bp_lat", 64'(lat), 64'd64);
        held_data = bus.mdu2wb_data;
        chk("bp_data", held_data, 64'd42);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("bp_hold%0d", i),
                {bus.mdu2wb_data[57:0], bus.mdu2wb_rdidx, bus.mdu2wb_vld},
                {held_data[57:0], 5'd9, 1'b1});
            chk($sformatf("bp_disp_rdy%0d", i), 64'(bus.disp2mdu_rdy), 64'd0);
        end
        release_wb();

        // flush at BUSY cycle 10, then no writeback appears
        issue(MDU_DIVU, 1'b0, 64'd1000, 64'd10, 5'd3);
        repeat (9) @(posedge clk);
        @(negedge clk);
        bus.mdu_flush = 1'b1;
        @(posedge clk);
        #1;
        bus.mdu_flush = 1'b0;
        chk("flush_rdy", 64'(bus.disp2mdu_rdy), 64'd1);
        saw_vld = 1'b0;
        for (int i = 0; i < 70; i++) begin
            @(posedge clk);
            #1;
            saw_vld |= bus.mdu2wb_vld;
        end
        chk("flush_no_vld", 64'(saw_vld), 64'd0);
        run_op("post_flush", MDU_DIVU, 1'b0, 64'd1000, 64'd10, 5'd4, 64'd100, 64);

        // flush wins over mdu2wb_rdy in DONE; both land in IDLE with vld low
        issue(MDU_DIV, 1'b0, 64'd9, 64'd0, 5'd20);
        wait_done(lat);
        chk("done_flush_lat", 64'(lat), 64'd1);
        @(negedge clk);
        bus.mdu_flush  = 1'b1;
        bus.mdu2wb_rdy = 1'b1;
        @(posedge clk);
        #1;
        bus.mdu_flush  = 1'b0;
        bus.mdu2wb_rdy = 1'b0;
        chk("done_flush_state", {62'd0, bus.disp2mdu_rdy, bus.mdu2wb_vld}, 64'b10);

        // flush while IDLE must not block acceptance
        bus.mdu_flush = 1'b1;
        issue(MDU_MULHU, 1'b0, 64'h1_0000_0000, 64'h1_0000_0000, 5'd21);
        bus.mdu_flush = 1'b0;
        wait_done(lat);
        chk("idle_flush_lat", 64'(lat), 64'd64);
        chk("idle_flush_data", bus.mdu2wb_data, 64'd1);
        release_wb();

        // asynchronous reset mid-BUSY
        issue(MDU_DIVU, 1'b0, 64'd100, 64'd7, 5'd22);
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_vld", 64'(bus.mdu2wb_vld), 64'd0);
        chk("arst_rdy", 64'(bus.disp2mdu_rdy), 64'd1);
        chk("arst_data", bus.mdu2wb_data, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op("post_reset_mul", MDU_MUL, 1'b0, 64'd3, 64'd4, 5'd23, 64'd12, 64);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not complete, errors %0d", errors);
        $fatal(1, "timeout");
    end
endmodule
